nt_node_monitor: RTL and testbench
==================================

// Module: nt_node_monitor
// PURPOSE
//  Multi-lane, parametrised rare-node cone with an activation monitor for trojan-detection benchmarks.
//  Each lane registers its stimulus inputs and evaluates a fixed 6-input rare-activation cone.
//  Per-lane counters track consecutive activation cycles; a global FSM raises a sticky alarm when any lane reaches a threshold.
//  Sits between the stimulus generator and the detection scoreboard in the Nt_Node test harness.
// PARAMETERS
//  LANES    4  number of independent cone lanes (1..32)
//  CNT_W    8  per-lane consecutive-hit counter width
//  OUT_REG  0  1 = node_out registered (+1 cycle latency), 0 = combinational from lane flops
// PORTS
//  I1470_clk   in   1         single clock, all state on rising edge
//  I1477_rst   in   1         reset, synchronous, active-low
//  en          in   1         1 = counters/FSM advance; 0 = hold (lane flops still capture)
//  clr         in   1         synchronous clear of counters, alarm, FSM
//  thresh      in   CNT_W     consecutive-hit count that triggers alarm; 0 = alarm disabled
//  in_a..in_c  in   LANES     registered cone inputs, bit i -> lane i
//  in_d..in_f  in   LANES     direct cone inputs, bit i -> lane i
//  node_out    out  LANES     per-lane cone output
//  hit_cnt     out  LANES*CNT_W  per-lane counters, lane i at [i*CNT_W +: CNT_W]
//  alarm       out  1         sticky alarm
//  alarm_lane  out  $clog2(LANES) (min 1)  lane that caused alarm
//  state       out  2         FSM state, for debug
// BEHAVIOUR
//  Reset (I1477_rst=0 at edge): lane flops qa/qb/qc=0, node_out=0, counters=0, alarm=0, alarm_lane=0, state=IDLE.
//  Lane i: qa<=in_a[i], qb<=in_b[i], qc<=in_c[i] every cycle, independent of en.
//   node = qb & qc & ~qa & ~in_d[i] & in_e[i] & in_f[i].
//   Latency: 1 cycle from in_a/b/c and 0 cycles from in_d/e/f when OUT_REG=0. Add 1 cycle to each when OUT_REG=1.
//   The counter input is the same node value that is driven on node_out.
//  Counter (en=1): node=1 -> cnt+1, saturating at 2^CNT_W-1 (no wrap); node=0 -> cnt=0.
//  Counter (en=0): hold.
//  Counter (clr=1): cnt=0. clr has priority over en and node.
//  FSM (advances only when en=1; clr forces IDLE):
//   IDLE  -> COUNT when any counter becomes non-zero.
//   COUNT -> IDLE when all counters return to 0.
//   COUNT -> ALARM when any lane's next count == thresh and thresh != 0.
//   ALARM is sticky: it exits only via clr or reset.
//  alarm=1 exactly while state==ALARM, asserted the same edge the counter reaches thresh.
//  alarm_lane: captured on the edge entering ALARM; if several lanes qualify simultaneously, the lowest index wins.
//   Held while in ALARM; cleared to 0 by clr.
//  Counters keep running in ALARM and do not affect alarm_lane.
//  Changing thresh mid-count takes effect on the next compare. A lane already >= the new thresh does not alarm
//   until its count equals thresh again (equality compare), so on saturation it never re-fires.
//  Reset or clr mid-operation: all state returns to reset values on that edge, with no residual alarm.
//  State encoding: IDLE=2'd0, COUNT=2'd1, ALARM=2'd2; 2'd3 is illegal and recovers to IDLE on the next edge.
// STRUCTURE
//  Shared package nt_mon_pkg: state typedef and encodings (NT_IDLE/NT_COUNT/NT_ALARM), LANE_IDX_W function (max(1,$clog2(LANES))).
//  One sub-module nt_mon_lane: input flops, cone, optional output flop, saturating counter, eq-thresh flag.
//  Top: generate LANES instances, OR-reduce non-zero flags, priority encoder for alarm_lane, FSM.
//  All flops use synchronous active-low reset on I1470_clk; no async paths.
// TESTING
//  1 Reset: drive all inputs =1 with I1477_rst=0 for 3 cycles -> node_out=0, hit_cnt=0, alarm=0, state=0.
//  2 Cone truth: LANES=4, lane0 qa=0 qb=1 qc=1 d=0 e=1 f=1 -> node_out[0]=1 one cycle after in_a/b/c applied.
//    Toggle each of the six inputs singly -> node_out[0]=0.
//  3 Threshold: thresh=5, hold lane2 active -> hit_cnt lane2 counts 1..5, alarm=1 on the edge cnt=5.
//    alarm_lane=2, state=2; drop activation -> alarm stays 1.
//  4 Tie and break: lanes 1 and 3 both reach thresh=3 on the same edge -> alarm_lane=1.
//    A lane breaking its run at cnt=2 -> cnt=0, state returns 1->0 when all lanes are idle.
//  5 Saturation and disable: CNT_W=4, thresh=0, 20 active cycles -> cnt saturates at 15, alarm stays 0.
//    en=0 for 3 cycles -> cnt holds.
//  6 clr/reset mid-run: assert clr while in ALARM with cnt=7 -> next edge alarm=0, cnt=0, alarm_lane=0, state=0.
//    Repeat with I1477_rst=0 -> same result.

Source files
------------

// File: rtl/nt_mon_pkg.sv
// Shared types and helpers for the Nt_Node rare-node monitor.
// Holds the FSM state encoding and the lane-index width function.
package nt_mon_pkg;

  typedef enum logic [1:0] {
    NT_IDLE  = 2'd0,
    NT_COUNT = 2'd1,
    NT_ALARM = 2'd2
  } nt_state_e;

  // Lane-index width; a single lane still gets a 1-bit index.
  function automatic int LANE_IDX_W(input int lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/nt_mon_lane.sv
// One monitor lane: input flops, 6-input rare-activation cone, optional output flop,
// saturating consecutive-hit counter and the "count just reached threshold" flag.
module nt_mon_lane #(
  parameter int CNT_W   = 8,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_c,
  input  logic             i_d,
  input  logic             i_e,
  input  logic             i_f,
  output logic             o_node,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nz_next,
  output logic             o_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_qa, r_qb, r_qc;
  logic             w_cone;
  logic             w_node;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_step;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_qa <= 1'b0;
      r_qb <= 1'b0;
      r_qc <= 1'b0;
    end else begin
      r_qa <= i_a;
      r_qb <= i_b;
      r_qc <= i_c;
    end
  end

  assign w_cone = r_qb & r_qc & ~r_qa & ~i_d & i_e & i_f;

  if (OUT_REG) begin : g_out_reg
    logic r_node;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_node <= 1'b0;
      else          r_node <= w_cone;
    end
    assign w_node = r_node;
  end else begin : g_out_comb
    assign w_node = w_cone;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_step    = 1'b0;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      if (!w_node) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_step    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end

  // Fires only on the increment that lands on thresh; a saturated or
  // already-past counter never re-fires.
  assign o_hit     = w_step && (i_thresh != '0) && (w_cnt_nxt == i_thresh);
  assign o_nz_next = |w_cnt_nxt;
  assign o_node    = w_node;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/nt_node_monitor.sv
// Multi-lane rare-node cone with a sticky activation alarm; the FSM watches all
// lane counters and latches the lowest lane that reaches the threshold.
module nt_node_monitor
  import nt_mon_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int CNT_W   = 8,
  parameter bit OUT_REG = 1'b0
) (
  input  logic                          I1470_clk,
  input  logic                          I1477_rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [CNT_W-1:0]              thresh,
  input  logic [LANES-1:0]              in_a,
  input  logic [LANES-1:0]              in_b,
  input  logic [LANES-1:0]              in_c,
  input  logic [LANES-1:0]              in_d,
  input  logic [LANES-1:0]              in_e,
  input  logic [LANES-1:0]              in_f,
  output logic [LANES-1:0]              node_out,
  output logic [LANES*CNT_W-1:0]        hit_cnt,
  output logic                          alarm,
  output logic [LANE_IDX_W(LANES)-1:0]  alarm_lane,
  output logic [1:0]                    state
);

  localparam int IDX_W = LANE_IDX_W(LANES);

  logic [LANES-1:0] w_nz;
  logic [LANES-1:0] w_hit;
  logic             w_any_nz;
  logic             w_any_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic [IDX_W-1:0] r_alarm_lane;
  nt_state_e        r_state;
  nt_state_e        w_state_nxt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nt_mon_lane #(
      .CNT_W   (CNT_W),
      .OUT_REG (OUT_REG)
    ) u_lane (
      .i_clk     (I1470_clk),
      .i_rst_n   (I1477_rst),
      .i_en      (en),
      .i_clr     (clr),
      .i_thresh  (thresh),
      .i_a       (in_a[g]),
      .i_b       (in_b[g]),
      .i_c       (in_c[g]),
      .i_d       (in_d[g]),
      .i_e       (in_e[g]),
      .i_f       (in_f[g]),
      .o_node    (node_out[g]),
      .o_cnt     (hit_cnt[g*CNT_W +: CNT_W]),
      .o_nz_next (w_nz[g]),
      .o_hit     (w_hit[g])
    );
  end

  assign w_any_nz  = |w_nz;
  assign w_any_hit = |w_hit;

  // Scan from the top so the lowest qualifying lane is written last and wins.
  always_comb begin
    w_hit_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = NT_IDLE;
    end else begin
      case (r_state)
        NT_IDLE: begin
          if (en && w_any_hit)     w_state_nxt = NT_ALARM;
          else if (en && w_any_nz) w_state_nxt = NT_COUNT;
        end
        NT_COUNT: begin
          if (en && w_any_hit)      w_state_nxt = NT_ALARM;
          else if (en && !w_any_nz) w_state_nxt = NT_IDLE;
        end
        NT_ALARM: w_state_nxt = NT_ALARM;
        default:  w_state_nxt = NT_IDLE;
      endcase
    end
  end

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) r_state <= NT_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst || clr) begin
      r_alarm_lane <= '0;
    end else if (w_state_nxt == NT_ALARM && r_state != NT_ALARM) begin
      r_alarm_lane <= w_hit_idx;
    end
  end

  assign alarm      = (r_state == NT_ALARM);
  assign alarm_lane = r_alarm_lane;
  assign state      = r_state;

endmodule

// File: tb/tb_nt_node_monitor.sv
// Directed bench for nt_node_monitor: a cycle model pushes expected outputs to a
// scoreboard as stimulus is driven; they are popped and compared after each edge.
module tb_nt_node_monitor;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic                   clr;
  logic [CNT_W-1:0]       thresh;
  logic [LANES-1:0]       in_a, in_b, in_c, in_d, in_e, in_f;
  logic [LANES-1:0]       node_out;
  logic [LANES*CNT_W-1:0] hit_cnt;
  logic                   alarm;
  logic [1:0]             alarm_lane;
  logic [1:0]             state;

  nt_node_monitor #(.LANES(LANES), .CNT_W(CNT_W), .OUT_REG(1'b0)) dut (
    .I1470_clk  (clk),
    .I1477_rst  (rst_n),
    .en         (en),
    .clr        (clr),
    .thresh     (thresh),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .in_d       (in_d),
    .in_e       (in_e),
    .in_f       (in_f),
    .node_out   (node_out),
    .hit_cnt    (hit_cnt),
    .alarm      (alarm),
    .alarm_lane (alarm_lane),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]       node;
    logic [LANES*CNT_W-1:0] cnt;
    logic                   alarm;
    logic [1:0]             lane;
    logic [1:0]             st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  logic [LANES-1:0] m_qa = '0, m_qb = '0, m_qc = '0;
  int               m_cnt[LANES];
  int               m_st   = 0;
  int               m_lane = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs currently driven.
  task automatic model_push();
    exp_t             e;
    logic [LANES-1:0] node_pre;
    int               hit_lane;
    bit               any_nz;
    node_pre = m_qb & m_qc & ~m_qa & ~in_d & in_e & in_f;
    if (!rst_n) begin
      m_qa = '0; m_qb = '0; m_qc = '0;
      for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
      m_st = 0; m_lane = 0;
    end else begin
      m_qa = in_a; m_qb = in_b; m_qc = in_c;
      if (clr) begin
        for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
        m_st = 0; m_lane = 0;
      end else if (en) begin
        hit_lane = -1;
        any_nz   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          if (node_pre[i]) begin
            if (m_cnt[i] < (1 << CNT_W) - 1) begin
              m_cnt[i]++;
              if (thresh != 0 && m_cnt[i] == int'(thresh) && hit_lane < 0) hit_lane = i;
            end
          end else begin
            m_cnt[i] = 0;
          end
          if (m_cnt[i] != 0) any_nz = 1'b1;
        end
        if (m_st != 2) begin
          if (hit_lane >= 0) begin
            m_st   = 2;
            m_lane = hit_lane;
          end else begin
            m_st = any_nz ? 1 : 0;
          end
        end
      end
    end
    e.node = m_qb & m_qc & ~m_qa & ~in_d & in_e & in_f;
    for (int i = 0; i < LANES; i++) e.cnt[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
    e.alarm = (m_st == 2);
    e.lane  = m_lane[1:0];
    e.st    = m_st[1:0];
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check($sformatf("c%0d node_out", cyc), node_out, e.node);
    check($sformatf("c%0d hit_cnt", cyc), hit_cnt, e.cnt);
    check($sformatf("c%0d alarm", cyc), alarm, e.alarm);
    check($sformatf("c%0d alarm_lane", cyc), alarm_lane, e.lane);
    check($sformatf("c%0d state", cyc), state, e.st);
  endtask

  // Drive the active pattern (qa=0 qb=qc=1, d=0 e=f=1) on the lanes in mask.
  task automatic act(input logic [LANES-1:0] mask);
    in_a = '0; in_b = mask; in_c = mask;
    in_d = '0; in_e = mask; in_f = mask;
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) m_cnt[i] = 0;

    // Reset with every input high.
    rst_n = 1'b0; en = 1'b1; clr = 1'b1; thresh = '1;
    in_a = '1; in_b = '1; in_c = '1; in_d = '1; in_e = '1; in_f = '1;
    repeat (3) cycle();
    check("rst node_out", node_out, 4'h0);
    check("rst hit_cnt", hit_cnt, 16'h0);
    check("rst alarm", alarm, 1'b0);
    check("rst state", state, 2'd0);

    rst_n = 1'b1; clr = 1'b0; thresh = '0;
    act('0);
    cycle();

    // Cone truth on lane 0, then each input flipped singly.
    act(4'b0001);
    cycle();
    check("cone active", node_out[0], 1'b1);
    for (int k = 0; k < 6; k++) begin
      act(4'b0001);
      cycle();
      case (k)
        0: in_a[0] = 1'b1;
        1: in_b[0] = 1'b0;
        2: in_c[0] = 1'b0;
        3: in_d[0] = 1'b1;
        4: in_e[0] = 1'b0;
        default: in_f[0] = 1'b0;
      endcase
      cycle();
      check($sformatf("cone flip%0d", k), node_out[0], 1'b0);
    end

    // Threshold 5 on lane 2.
    act('0); clr = 1'b1; cycle(); clr = 1'b0;
    thresh = 4'd5;
    act(4'b0100);
    repeat (5) cycle();
    check("th5 pre cnt", hit_cnt[2*CNT_W +: CNT_W], 4'd4);
    check("th5 pre alarm", alarm, 1'b0);
    cycle();
    check("th5 cnt", hit_cnt[2*CNT_W +: CNT_W], 4'd5);
    check("th5 alarm", alarm, 1'b1);
    check("th5 lane", alarm_lane, 2'd2);
    check("th5 state", state, 2'd2);
    act('0);
    repeat (2) cycle();
    check("th5 sticky", alarm, 1'b1);
    check("th5 cnt drop", hit_cnt[2*CNT_W +: CNT_W], 4'd0);

    // Lanes 1 and 3 reach thresh together.
    clr = 1'b1; cycle(); clr = 1'b0;
    thresh = 4'd3;
    act(4'b1010);
    repeat (4) cycle();
    check("tie alarm", alarm, 1'b1);
    check("tie lane", alarm_lane, 2'd1);

    // Run broken at cnt=2.
    clr = 1'b1; act('0); cycle(); clr = 1'b0;
    thresh = 4'd5;
    act(4'b0001);
    repeat (3) cycle();
    check("brk cnt2", hit_cnt[0 +: CNT_W], 4'd2);
    check("brk state1", state, 2'd1);
    act('0);
    cycle();
    check("brk cnt0", hit_cnt[0 +: CNT_W], 4'd0);
    check("brk state0", state, 2'd0);

    // Saturation with alarm disabled, then hold with en=0.
    thresh = '0;
    act(4'b0001);
    repeat (20) cycle();
    check("sat cnt", hit_cnt[0 +: CNT_W], 4'd15);
    check("sat alarm", alarm, 1'b0);
    en = 1'b0;
    act('0);
    repeat (3) cycle();
    check("hold cnt", hit_cnt[0 +: CNT_W], 4'd15);
    act(4'b0001);
    cycle();
    en = 1'b1; thresh = 4'd15;
    repeat (3) cycle();
    check("sat no refire", alarm, 1'b0);
    check("sat cnt kept", hit_cnt[0 +: CNT_W], 4'd15);

    // clr while in ALARM.
    clr = 1'b1; act('0); cycle(); clr = 1'b0;
    thresh = 4'd7;
    act(4'b1000);
    repeat (8) cycle();
    check("clr pre cnt", hit_cnt[3*CNT_W +: CNT_W], 4'd7);
    check("clr pre alarm", alarm, 1'b1);
    check("clr pre lane", alarm_lane, 2'd3);
    clr = 1'b1;
    cycle();
    check("clr alarm", alarm, 1'b0);
    check("clr cnt", hit_cnt, 16'h0);
    check("clr lane", alarm_lane, 2'd0);
    check("clr state", state, 2'd0);
    clr = 1'b0;

    // Reset while in ALARM.
    repeat (7) cycle();
    check("rst2 pre alarm", alarm, 1'b1);
    rst_n = 1'b0;
    cycle();
    check("rst2 alarm", alarm, 1'b0);
    check("rst2 cnt", hit_cnt, 16'h0);
    check("rst2 lane", alarm_lane, 2'd0);
    check("rst2 state", state, 2'd0);
    check("rst2 node", node_out, 4'h0);
    rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
